// File: rtl/word_serializer.sv
// Parallel-to-serial converter: loads a WIDTH-bit word and emits it LSB first
// over a valid/ready bit stream, pulsing done once the final bit is taken.
module word_serializer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             st,
  input  logic [WIDTH-1:0] in,
  output logic             in_ready,
  output logic             bit_out,
  output logic             bit_valid,
  input  logic             bit_ready,
  output logic             bit_last,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [WIDTH-1:0] r_shiftReg;
  logic [CW-1:0]    r_bitCount;
  logic             r_done;

  logic w_load;
  logic w_xfer;
  logic w_atLast;
  logic w_lastXfer;

  assign w_atLast   = (r_bitCount == CW'(WIDTH - 1));
  assign w_load     = (r_state == IDLE) && st;
  assign w_xfer     = (r_state == SHIFT) && bit_ready;
  assign w_lastXfer = w_xfer && w_atLast;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_load)     w_nextState = SHIFT;
      SHIFT:   if (w_lastXfer) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Counter wrap after the final bit is harmless: every load clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shiftReg <= '0;
      r_bitCount <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done <= w_lastXfer;
      if (w_load) begin
        r_shiftReg <= in;
        r_bitCount <= '0;
      end else if (w_xfer) begin
        r_shiftReg <= {1'b0, r_shiftReg[WIDTH-1:1]};
        r_bitCount <= r_bitCount + CW'(1);
      end
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign bit_valid = (r_state == SHIFT);
  assign bit_out   = (r_state == SHIFT) ? r_shiftReg[0] : 1'b0;
  assign bit_last  = (r_state == SHIFT) && w_atLast;
  assign done      = r_done;

endmodule

// File: tb/tb_word_serializer.sv
// Self-checking bench for word_serializer: fixed vector table, directed corner
// sequences and random traffic against a queue-of-bits reference model.
module tb_word_serializer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        st = 1'b0;
  logic [15:0] in = '0;
  logic        bit_ready = 1'b0;
  logic        in_ready, bit_out, bit_valid, bit_last, done;

  logic       st4 = 1'b0;
  logic [3:0] in4 = '0;
  logic       br4 = 1'b0;
  logic       rdy4, out4, val4, last4, done4;

  int total = 0;
  int bad = 0;

  bit modelQ[$];
  bit modelDone = 1'b0;

  int validCycles;
  int doneCount;
  bit delivered[$];

  typedef struct {
    logic        s;
    logic [15:0] d;
    logic        b;
    logic        eOut;
    logic        eValid;
    logic        eLast;
    logic        eDone;
    logic        eReady;
  } vec_t;

  vec_t vecs[19];

  always #5 clk = ~clk;

  word_serializer #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .st(st), .in(in), .in_ready(in_ready),
    .bit_out(bit_out), .bit_valid(bit_valid), .bit_ready(bit_ready),
    .bit_last(bit_last), .done(done)
  );

  word_serializer #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .st(st4), .in(in4), .in_ready(rdy4),
    .bit_out(out4), .bit_valid(val4), .bit_ready(br4),
    .bit_last(last4), .done(done4)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    modelQ.delete();
    modelDone = 1'b0;
  endtask

  // One rising edge of the reference: a word is a queue of bits to hand out.
  task automatic modelUpdate(input logic s, input logic [15:0] d, input logic b);
    bit nd;
    nd = 1'b0;
    if (modelQ.size() == 0) begin
      if (s) for (int i = 0; i < 16; i++) modelQ.push_back(d[i]);
    end else if (b) begin
      void'(modelQ.pop_front());
      if (modelQ.size() == 0) nd = 1'b1;
    end
    modelDone = nd;
  endtask

  task automatic checkModel();
    bit busy;
    busy = (modelQ.size() != 0);
    checkOutput("in_ready", in_ready, !busy);
    checkOutput("bit_valid", bit_valid, busy);
    checkOutput("bit_out", bit_out, busy ? modelQ[0] : 1'b0);
    checkOutput("bit_last", bit_last, modelQ.size() == 1);
    checkOutput("done", done, modelDone);
  endtask

  task automatic clearStats();
    validCycles = 0;
    doneCount = 0;
    delivered.delete();
  endtask

  task automatic applyStimulus(input logic s, input logic [15:0] d, input logic b);
    @(negedge clk);
    checkModel();
    if (bit_valid) validCycles++;
    if (done) doneCount++;
    if (bit_valid && b) delivered.push_back(bit_out);
    st = s;
    in = d;
    bit_ready = b;
    @(posedge clk);
    modelUpdate(s, d, b);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " in_ready"}, in_ready, 1'b1);
    checkOutput({tag, " bit_out"}, bit_out, 1'b0);
    checkOutput({tag, " bit_valid"}, bit_valid, 1'b0);
    checkOutput({tag, " bit_last"}, bit_last, 1'b0);
    checkOutput({tag, " done"}, done, 1'b0);
  endtask

  initial begin
    bit seqA5C3[16];
    bit exp4[4];
    logic [31:0] wordPair;

    seqA5C3 = '{1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1};
    exp4 = '{0,1,0,1};

    vecs[0] = '{s:1'b1, d:16'hA5C3, b:1'b1, eOut:1'b0, eValid:1'b0, eLast:1'b0, eDone:1'b0, eReady:1'b1};
    for (int i = 1; i <= 16; i++)
      vecs[i] = '{s:1'b0, d:16'h0000, b:1'b1, eOut:seqA5C3[i-1], eValid:1'b1,
                  eLast:(i == 16), eDone:1'b0, eReady:1'b0};
    vecs[17] = '{s:1'b0, d:16'h0000, b:1'b1, eOut:1'b0, eValid:1'b0, eLast:1'b0, eDone:1'b1, eReady:1'b1};
    vecs[18] = '{s:1'b0, d:16'h0000, b:1'b1, eOut:1'b0, eValid:1'b0, eLast:1'b0, eDone:1'b0, eReady:1'b1};

    // Power-up reset, spanning a rising edge.
    #2;
    checkResetValues("por");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    modelReset();
    clearStats();

    $display("[TB] vector table A5C3");
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      checkOutput("vec bit_out", bit_out, vecs[i].eOut);
      checkOutput("vec bit_valid", bit_valid, vecs[i].eValid);
      checkOutput("vec bit_last", bit_last, vecs[i].eLast);
      checkOutput("vec done", done, vecs[i].eDone);
      checkOutput("vec in_ready", in_ready, vecs[i].eReady);
      st = vecs[i].s;
      in = vecs[i].d;
      bit_ready = vecs[i].b;
      @(posedge clk);
      modelUpdate(vecs[i].s, vecs[i].d, vecs[i].b);
    end

    $display("[TB] backpressure 8001");
    applyStimulus(1'b1, 16'h8001, 1'b0);
    clearStats();
    for (int i = 0; i < 32; i++) applyStimulus(1'b0, 16'h0000, logic'(i % 2));
    applyStimulus(1'b0, 16'h0000, 1'b1);
    applyStimulus(1'b0, 16'h0000, 1'b1);
    checkOutput("bp validCycles", validCycles, 32);
    checkOutput("bp doneCount", doneCount, 1);
    checkOutput("bp bitCount", delivered.size(), 16);
    for (int i = 0; i < 16 && i < delivered.size(); i++)
      checkOutput("bp bit", delivered[i], (16'h8001 >> i) & 1);

    $display("[TB] st ignored mid-word");
    applyStimulus(1'b1, 16'h0000, 1'b1);
    clearStats();
    for (int i = 0; i < 16; i++)
      applyStimulus((i >= 4 && i < 15), 16'hFFFF, 1'b1);
    applyStimulus(1'b0, 16'h0000, 1'b1);
    applyStimulus(1'b0, 16'h0000, 1'b1);
    checkOutput("ign validCycles", validCycles, 16);
    checkOutput("ign ones", delivered.sum() with (int'(item)), 0);

    $display("[TB] back-to-back 1234/FEDC");
    applyStimulus(1'b1, 16'h1234, 1'b1);
    clearStats();
    for (int i = 0; i < 16; i++) applyStimulus(1'b0, 16'h0000, 1'b1);
    applyStimulus(1'b1, 16'hFEDC, 1'b1);
    for (int i = 0; i < 16; i++) applyStimulus(1'b0, 16'h0000, 1'b1);
    checkOutput("b2b validCycles", validCycles, 32);
    checkOutput("b2b doneCount", doneCount, 1);
    wordPair = {16'hFEDC, 16'h1234};
    checkOutput("b2b bitCount", delivered.size(), 32);
    for (int i = 0; i < 32 && i < delivered.size(); i++)
      checkOutput("b2b bit", delivered[i], wordPair[i]);
    applyStimulus(1'b0, 16'h0000, 1'b1);
    applyStimulus(1'b0, 16'h0000, 1'b1);

    $display("[TB] random traffic");
    for (int i = 0; i < 600; i++)
      applyStimulus(($urandom_range(0, 3) == 0), 16'($urandom), ($urandom_range(0, 3) != 0));
    for (int i = 0; i < 40; i++) applyStimulus(1'b0, 16'h0000, 1'b1);

    $display("[TB] reset mid-word BEEF");
    applyStimulus(1'b1, 16'hBEEF, 1'b1);
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, 16'h0000, 1'b1);
    @(negedge clk);
    checkOutput("pre-rst bit_valid", bit_valid, 1'b1);
    checkOutput("pre-rst bit_out", bit_out, (16'hBEEF >> 7) & 1);
    #1 rst_n = 1'b0;
    #1 checkResetValues("rst");
    st = 1'b1;
    in = 16'h0003;
    bit_ready = 1'b1;
    #1 rst_n = 1'b1;
    modelReset();
    @(posedge clk);
    modelUpdate(1'b1, 16'h0003, 1'b1);
    clearStats();
    for (int i = 0; i < 18; i++) applyStimulus(1'b0, 16'h0000, 1'b1);
    checkOutput("rst doneCount", doneCount, 1);
    checkOutput("rst bitCount", delivered.size(), 16);
    for (int i = 0; i < 16 && i < delivered.size(); i++)
      checkOutput("rst bit", delivered[i], (i < 2));

    $display("[TB] WIDTH=4 word 1010");
    @(negedge clk);
    checkOutput("w4 in_ready", rdy4, 1'b1);
    st4 = 1'b1;
    in4 = 4'b1010;
    br4 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      st4 = 1'b0;
      checkOutput("w4 bit_out", out4, exp4[i]);
      checkOutput("w4 bit_valid", val4, 1'b1);
      checkOutput("w4 bit_last", last4, (i == 3));
      checkOutput("w4 in_ready", rdy4, 1'b0);
      checkOutput("w4 done", done4, 1'b0);
    end
    @(negedge clk);
    checkOutput("w4 done pulse", done4, 1'b1);
    checkOutput("w4 idle valid", val4, 1'b0);
    @(negedge clk);
    checkOutput("w4 done clear", done4, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
